oa_writer: RTL and testbench
============================

# oa_writer

Output-activation writer downstream of the vector requant stage in the MMA datapath. Accepts requantized int8 row segments, packs them into bus-width words with byte masks, and writes matrix C to memory over ICB. Bus access goes through the controller's arbiter using `write_oa_req`/`write_oa_granted`. The block reports per-segment completion (`write_done`) and whole-matrix completion (`oa_calc_over`) back to the controller.

## Interface
- `SIZE`, 16, lanes (int8 bytes) per input segment
- `BUS_WIDTH`, 32, ICB data width; BYTES = BUS_WIDTH/8
- `REG_WIDTH`, 32, configuration/address width

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `init_cfg_oa` in 1: single-cycle pulse; latch config and restart
- `dst_base` in REG_WIDTH: C base byte address
- `dst_row_stride_b` in REG_WIDTH: C row stride in bytes
- `n` in REG_WIDTH: C rows
- `m` in REG_WIDTH: C columns
- `in_valid` in 1: segment valid
- `in_ready` out 1: segment accepted when both high
- `in_data` in SIZE*8: lane i = byte for column t*SIZE+i
- `write_oa_req` out 1: bus request to arbiter
- `write_oa_granted` in 1: bus grant
- `write_done` out 1: single-cycle pulse when a segment's last response returns
- `oa_calc_over` out 1: single-cycle pulse after the final segment of the matrix
- `wr_err` out 1: sticky; set by any `rsp_err`, cleared by `init_cfg_oa`
- `icb_cmd_valid` out 1: command valid
- `icb_cmd_ready` in 1: command ready
- `icb_cmd_addr` out REG_WIDTH: word-aligned address
- `icb_cmd_read` out 1: constant 0
- `icb_cmd_wdata` out BUS_WIDTH: write data
- `icb_cmd_wmask` out BYTES: byte-enable mask
- `icb_rsp_valid` in 1: response valid
- `icb_rsp_ready` out 1: constant 1
- `icb_rsp_err` in 1: response error

## Operation
- Segment order: tile t = 0..T-1 with T = ceil(m/SIZE). Within each tile, rows r = 0..n-1, one segment per row.
- Segment address: A = dst_base + r*dst_row_stride_b + t*SIZE. Address is maintained incrementally: add the stride per row; at each tile end, reload base + (t+1)*SIZE. No multiplier.
- Valid byte count: cnt = min(SIZE, m - t*SIZE). Lanes at index cnt and above are ignored.
- Words per segment: W = ceil((A mod BYTES + cnt)/BYTES). Word j address = (A & ~(BYTES-1)) + j*BYTES.
- Byte b of word j maps to segment byte (j*BYTES + b - A mod BYTES). `wmask` bit b = 1 only if that index is in [0, cnt).
- FSM states:
  - IDLE: wait for `init_cfg_oa`. On the pulse, latch config, set r=t=0, go to WAIT_DATA.
  - WAIT_DATA: `in_ready`=1. On handshake, capture `in_data` into the segment buffer and go to REQ.
  - REQ: `write_oa_req`=1. On `write_oa_granted`, go to CMD.
  - CMD: issue words 0..W-1, one per `cmd_valid && cmd_ready`. After the last word, go to RSP.
  - RSP: wait until the response count equals W. Then pulse `write_done`, drop `write_oa_req` in the same cycle, and advance r/t.
    - If this was the last segment (r=n-1, t=T-1): pulse `oa_calc_over` in that same cycle and go to IDLE.
    - Otherwise go to WAIT_DATA.
- `write_oa_req` is held from REQ through the final response; the grant is never released mid-segment.
- Responses are counted in CMD as well as RSP. A response accepted in the same cycle as a command counts.
- Errors do not stop the sequence; they only set `wr_err`.
- `init_cfg_oa` in any state aborts the current segment:
  - `write_oa_req` and `cmd_valid` drop next cycle;
  - config is re-latched; FSM goes to WAIT_DATA.
  - Outstanding responses after an abort are accepted and discarded.

## Timing
- Reset values: `in_ready`, `write_oa_req`, `write_done`, `oa_calc_over`, `wr_err`, `icb_cmd_valid` = 0; `cmd_addr`/`wdata`/`wmask` = 0. `rsp_ready` = 1.
- Outputs are registered except `icb_rsp_ready` and `icb_cmd_read`.
- `in_ready` is high only in WAIT_DATA, so at most one segment is buffered.
- `write_oa_req` rises the cycle after input capture.
- First `cmd_valid` appears the cycle after grant is sampled.
- Commands are back-to-back while `cmd_ready`=1. Address, data and mask are held stable while `cmd_valid && !cmd_ready`.
- `write_done`/`oa_calc_over` rise the cycle after the W-th response is accepted.
- Minimum segment latency with zero-wait bus: 1 capture + 1 req + 1 grant + W cmd + 1 rsp.

## Test plan
- Aligned full-tile path:
  - Stimulus: base=0x1000, stride=16, n=2, m=16, BUS=32, zero-wait bus.
  - Required: 8 writes; addresses 0x1000..0x101C; all masks 0xF; 2 `write_done` pulses; `oa_calc_over` with the second pulse.
- Partial last tile:
  - Stimulus: m=20, n=1, base=0x2000.
  - Required: tile 0 is 4 words; tile 1 is one word at 0x2010 with mask 0xF.
  - Required: `oa_calc_over` after the tile-1 segment only.
- Unaligned base:
  - Stimulus: base=0x3002, m=4, n=1, data 0x44332211.
  - Required: word 0x3000 with wdata[31:16]=0x2211, mask 0xC.
  - Required: word 0x3004 with wdata[15:0]=0x4433, mask 0x3.
- Backpressure and grant delay:
  - Stimulus: grant delayed 5 cycles; `cmd_ready` toggles every cycle; responses delayed 3 cycles.
  - Required: command fields stable while stalled; `write_oa_req` continuous; exactly one `write_done`.
- Error response:
  - Stimulus: `rsp_err`=1 on word 2 of segment 0.
  - Required: `wr_err`=1 and stays set through the end; sequence completes normally.
  - Required: the next `init_cfg_oa` clears `wr_err`.
- Abort mid-operation:
  - Stimulus: `init_cfg_oa` asserted during CMD of segment 1.
  - Required: `write_oa_req` and `cmd_valid` low next cycle; no `write_done`.
  - Required: the next segment starts at the new base with r=t=0.
- Async reset mid-RSP:
  - Required: all outputs return to 0 immediately and the FSM is in IDLE.

Source files
------------

// File: rtl/oa_writer.sv
// oa_writer: output-activation writer for the MMA datapath.
// Takes requantized int8 row segments (SIZE lanes), packs each segment into
// BUS_WIDTH words with byte masks and writes matrix C to memory over ICB.
// Segments arrive tile-major: for each column tile t, rows 0..n-1.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   init_cfg_oa           pulse: latch dst_base/dst_row_stride_b/n/m, restart
//   in_valid/in_ready     segment handshake, in_data lane i = column t*SIZE+i
//   write_oa_req/granted  bus arbitration with the controller
//   write_done            pulse when a segment's last response returns
//   oa_calc_over          pulse with write_done of the final segment
//   wr_err                sticky error flag, cleared by init_cfg_oa
//   icb_cmd_* / icb_rsp_* ICB write command and response channels
module oa_writer #(
    parameter int SIZE      = 16,
    parameter int BUS_WIDTH = 32,
    parameter int REG_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init_cfg_oa,
    input  logic [REG_WIDTH-1:0]   dst_base,
    input  logic [REG_WIDTH-1:0]   dst_row_stride_b,
    input  logic [REG_WIDTH-1:0]   n,
    input  logic [REG_WIDTH-1:0]   m,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SIZE*8-1:0]      in_data,
    output logic                   write_oa_req,
    input  logic                   write_oa_granted,
    output logic                   write_done,
    output logic                   oa_calc_over,
    output logic                   wr_err,
    output logic                   icb_cmd_valid,
    input  logic                   icb_cmd_ready,
    output logic [REG_WIDTH-1:0]   icb_cmd_addr,
    output logic                   icb_cmd_read,
    output logic [BUS_WIDTH-1:0]   icb_cmd_wdata,
    output logic [BUS_WIDTH/8-1:0] icb_cmd_wmask,
    input  logic                   icb_rsp_valid,
    output logic                   icb_rsp_ready,
    input  logic                   icb_rsp_err
);

    localparam int BYTES = BUS_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int LANEW = $clog2(SIZE);
    localparam int CNTW  = LANEW + 1;
    localparam int WCW   = $clog2(SIZE + BYTES) + 1;
    localparam int PW    = WCW + OFFW;

    typedef enum logic [2:0] {IDLE, WAIT_DATA, REQ, CMD, RSP} state_t;

    state_t state_reg, state_next;

    logic [REG_WIDTH-1:0] base_reg, stride_reg, n_reg, m_reg;
    logic [REG_WIDTH-1:0] row_reg, col_reg, seg_addr_reg;
    logic [7:0]           seg_bytes_reg [SIZE];
    logic [WCW-1:0]       word_idx_reg, issued_reg, rsp_cnt_reg, discard_reg;

    logic [REG_WIDTH-1:0] remain, col_next, aligned, build_addr;
    logic [CNTW-1:0]      cnt;
    logic [OFFW-1:0]      offset;
    logic [WCW-1:0]       words, j_sel, rsp_cnt_next, outstanding;
    logic [BUS_WIDTH-1:0] build_data;
    logic [BYTES-1:0]     build_mask;
    logic capture, cmd_fire, in_seg, rsp_count_en, discard_dec;
    logic last_word, last_fire, seg_done, last_seg;

    assign icb_cmd_read  = 1'b0;
    assign icb_rsp_ready = 1'b1;

    // Geometry of the current segment, derived from the running address/column.
    assign remain   = m_reg - col_reg;
    assign cnt      = (remain >= REG_WIDTH'(SIZE)) ? CNTW'(SIZE) : remain[CNTW-1:0];
    assign offset   = seg_addr_reg[OFFW-1:0];
    assign words    = WCW'((PW'(offset) + PW'(cnt) + PW'(BYTES - 1)) >> OFFW);
    assign aligned  = {seg_addr_reg[REG_WIDTH-1:OFFW], {OFFW{1'b0}}};
    assign col_next = col_reg + REG_WIDTH'(SIZE);
    assign last_seg = (row_reg == n_reg - REG_WIDTH'(1)) && (col_next >= m_reg);

    // Word being prepared for the command register: word 0 on grant,
    // otherwise the one after the word currently presented.
    assign j_sel      = (state_reg == REQ) ? '0 : word_idx_reg + WCW'(1);
    assign build_addr = aligned + (REG_WIDTH'(j_sel) << OFFW);

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        logic [PW-1:0] pos;
        logic          hit;
        // pos is the byte position relative to the aligned segment start;
        // subtracting the offset gives the segment lane it carries.
        assign pos = {j_sel, OFFW'(gi)};
        assign hit = (pos >= PW'(offset)) && ((pos - PW'(offset)) < PW'(cnt));
        assign build_mask[gi]        = hit;
        assign build_data[gi*8 +: 8] = hit ? seg_bytes_reg[LANEW'(pos - PW'(offset))] : 8'h00;
    end

    assign capture      = (state_reg == WAIT_DATA) && in_valid && in_ready;
    assign cmd_fire     = icb_cmd_valid && icb_cmd_ready;
    assign in_seg       = (state_reg == CMD) || (state_reg == RSP);
    // Responses belonging to an aborted segment drain through discard_reg first.
    assign discard_dec  = icb_rsp_valid && (discard_reg != '0);
    assign rsp_count_en = icb_rsp_valid && (discard_reg == '0) && in_seg;
    assign rsp_cnt_next = rsp_cnt_reg + WCW'(rsp_count_en);
    assign outstanding  = in_seg ? (issued_reg + WCW'(cmd_fire) - rsp_cnt_next) : '0;
    assign last_word    = (word_idx_reg == words - WCW'(1));
    assign last_fire    = (state_reg == CMD) && cmd_fire && last_word;
    assign seg_done     = (state_reg == RSP) && (rsp_cnt_next == words);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (init_cfg_oa) begin
            state_next = WAIT_DATA;
        end else begin
            case (state_reg)
                IDLE:      state_next = IDLE;
                WAIT_DATA: if (capture) state_next = REQ;
                REQ:       if (write_oa_granted) state_next = CMD;
                CMD:       if (last_fire) state_next = RSP;
                RSP:       if (seg_done) state_next = last_seg ? IDLE : WAIT_DATA;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg      <= '0;
            stride_reg    <= '0;
            n_reg         <= '0;
            m_reg         <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            seg_addr_reg  <= '0;
            word_idx_reg  <= '0;
            issued_reg    <= '0;
            rsp_cnt_reg   <= '0;
            discard_reg   <= '0;
            in_ready      <= 1'b0;
            write_oa_req  <= 1'b0;
            write_done    <= 1'b0;
            oa_calc_over  <= 1'b0;
            wr_err        <= 1'b0;
            icb_cmd_valid <= 1'b0;
            icb_cmd_addr  <= '0;
            icb_cmd_wdata <= '0;
            icb_cmd_wmask <= '0;
            for (int i = 0; i < SIZE; i++) seg_bytes_reg[i] <= '0;
        end else begin
            in_ready     <= (state_next == WAIT_DATA);
            write_oa_req <= (state_next == REQ) || (state_next == CMD) || (state_next == RSP);
            write_done   <= 1'b0;
            oa_calc_over <= 1'b0;
            if (init_cfg_oa) begin
                base_reg      <= dst_base;
                stride_reg    <= dst_row_stride_b;
                n_reg         <= n;
                m_reg         <= m;
                row_reg       <= '0;
                col_reg       <= '0;
                seg_addr_reg  <= dst_base;
                wr_err        <= 1'b0;
                icb_cmd_valid <= 1'b0;
                discard_reg   <= discard_reg - WCW'(discard_dec) + outstanding;
            end else begin
                discard_reg <= discard_reg - WCW'(discard_dec);
                if (icb_rsp_valid && icb_rsp_err) wr_err <= 1'b1;
                if (capture) begin
                    for (int i = 0; i < SIZE; i++) seg_bytes_reg[i] <= in_data[i*8 +: 8];
                    word_idx_reg <= '0;
                    issued_reg   <= '0;
                    rsp_cnt_reg  <= '0;
                end
                if ((state_reg == REQ) && write_oa_granted) begin
                    icb_cmd_valid <= 1'b1;
                    icb_cmd_addr  <= build_addr;
                    icb_cmd_wdata <= build_data;
                    icb_cmd_wmask <= build_mask;
                end
                if ((state_reg == CMD) && cmd_fire) begin
                    issued_reg <= issued_reg + WCW'(1);
                    if (last_word) begin
                        icb_cmd_valid <= 1'b0;
                    end else begin
                        icb_cmd_addr  <= build_addr;
                        icb_cmd_wdata <= build_data;
                        icb_cmd_wmask <= build_mask;
                        word_idx_reg  <= word_idx_reg + WCW'(1);
                    end
                end
                if (in_seg) rsp_cnt_reg <= rsp_cnt_next;
                if (seg_done) begin
                    write_done   <= 1'b1;
                    oa_calc_over <= last_seg;
                    // Row step adds the stride; tile step reloads base + next column.
                    if (row_reg == n_reg - REG_WIDTH'(1)) begin
                        row_reg      <= '0;
                        col_reg      <= col_next;
                        seg_addr_reg <= base_reg + col_next;
                    end else begin
                        row_reg      <= row_reg + REG_WIDTH'(1);
                        seg_addr_reg <= seg_addr_reg + stride_reg;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_oa_writer.sv
// Bench for oa_writer: bus model with configurable grant delay, cmd_ready
// toggling and response delay; a byte-address reference model predicts the
// word stream of every matrix.
module tb_oa_writer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         init_cfg_oa;
    logic [31:0]  dst_base, dst_row_stride_b, n, m;
    logic         in_valid, in_ready;
    logic [127:0] in_data;
    logic         write_oa_req, write_oa_granted, write_done, oa_calc_over, wr_err;
    logic         icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0]  icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]   icb_cmd_wmask;
    logic         icb_rsp_valid, icb_rsp_ready, icb_rsp_err;

    always #5 clk = ~clk;

    oa_writer dut (
        .clk(clk), .rst_n(rst_n), .init_cfg_oa(init_cfg_oa),
        .dst_base(dst_base), .dst_row_stride_b(dst_row_stride_b), .n(n), .m(m),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .write_oa_req(write_oa_req), .write_oa_granted(write_oa_granted),
        .write_done(write_done), .oa_calc_over(oa_calc_over), .wr_err(wr_err),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_err(icb_rsp_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int ready_mode = 0, grant_delay = 0, rsp_delay = 0, err_idx = -1, cmd_num = 0;
    int cyc = 0, done_cnt = 0, over_cnt = 0, stall_err = 0, drop_err = 0, over_err = 0;
    bit allow_drop = 0;
    bit use_fixed = 0;
    logic [127:0] fixed_seg = '0;

    logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
    logic [3:0]  got_mask[$], exp_mask[$];
    int          rsp_due[$];
    bit          rsp_errq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus driver: grant after grant_delay cycles of request, cmd_ready mode,
    // in-order responses released at their due cycle.
    initial begin
        int req_cyc;
        req_cyc = 0;
        icb_cmd_ready = 1'b0;
        icb_rsp_valid = 1'b0;
        icb_rsp_err = 1'b0;
        write_oa_granted = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            icb_cmd_ready = (ready_mode == 0) ? 1'b1 : ~icb_cmd_ready;
            if (write_oa_req) begin
                if (req_cyc >= grant_delay) write_oa_granted = 1'b1;
                req_cyc++;
            end else begin
                write_oa_granted = 1'b0;
                req_cyc = 0;
            end
            icb_rsp_valid = 1'b0;
            icb_rsp_err = 1'b0;
            if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
                icb_rsp_valid = 1'b1;
                icb_rsp_err = rsp_errq[0];
                void'(rsp_due.pop_front());
                void'(rsp_errq.pop_front());
            end
        end
    end

    // Monitor: records fired commands, counts pulses, watches protocol rules.
    initial begin
        bit stall_prev, req_prev;
        logic [31:0] p_addr, p_data;
        logic [3:0]  p_mask;
        stall_prev = 0; req_prev = 0; p_addr = 0; p_data = 0; p_mask = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 0;
                req_prev = 0;
            end else begin
                if (stall_prev && !(icb_cmd_valid && icb_cmd_addr == p_addr &&
                                    icb_cmd_wdata == p_data && icb_cmd_wmask == p_mask))
                    stall_err++;
                stall_prev = icb_cmd_valid && !icb_cmd_ready;
                p_addr = icb_cmd_addr; p_data = icb_cmd_wdata; p_mask = icb_cmd_wmask;
                if (req_prev && !write_oa_req && !write_done && !allow_drop) drop_err++;
                req_prev = write_oa_req;
                if (write_done) done_cnt++;
                if (oa_calc_over) begin
                    over_cnt++;
                    if (!write_done) over_err++;
                end
                if (icb_cmd_valid && icb_cmd_ready) begin
                    got_addr.push_back(icb_cmd_addr);
                    got_data.push_back(icb_cmd_wdata);
                    got_mask.push_back(icb_cmd_wmask);
                    rsp_due.push_back(cyc + 1 + rsp_delay);
                    rsp_errq.push_back(cmd_num == err_idx);
                    cmd_num++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mask_bits(input logic [3:0] mk);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = mk[b] ? 8'hFF : 8'h00;
        return r;
    endfunction

    // Reference: every segment byte k lives at byte address a+k; the words
    // written are all aligned words touching [a, a+c).
    task automatic model_seg(input longint a, input int c, input logic [127:0] seg);
        longint first, last, ba;
        logic [31:0] d;
        logic [3:0]  mk;
        first = (a / 4) * 4;
        last  = ((a + c - 1) / 4) * 4;
        for (longint wa = first; wa <= last; wa += 4) begin
            d = '0; mk = '0;
            for (int bb = 0; bb < 4; bb++) begin
                ba = wa + bb;
                if (ba >= a && ba < a + c) begin
                    mk[bb] = 1'b1;
                    d[8*bb +: 8] = seg[8*int'(ba - a) +: 8];
                end
            end
            exp_addr.push_back(wa[31:0]);
            exp_data.push_back(d);
            exp_mask.push_back(mk);
        end
    endtask

    task automatic pulse_init(input logic [31:0] b, s, nn, mm);
        @(posedge clk); #1;
        dst_base = b; dst_row_stride_b = s; n = nn; m = mm;
        init_cfg_oa = 1'b1;
        @(posedge clk); #1;
        init_cfg_oa = 1'b0;
    endtask

    task automatic send_seg(input logic [127:0] d);
        int k;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 300);
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (done_cnt < target && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    task automatic run_matrix(input logic [31:0] b, s, nn, mm, input bit do_init);
        int tt, d0, o0, idx, c, nw;
        logic [127:0] seg;
        got_addr.delete(); got_data.delete(); got_mask.delete();
        exp_addr.delete(); exp_data.delete(); exp_mask.delete();
        d0 = done_cnt;
        o0 = over_cnt;
        if (do_init) pulse_init(b, s, nn, mm);
        tt = (int'(mm) + 15) / 16;
        idx = 0;
        for (int t = 0; t < tt; t++) begin
            for (int r = 0; r < int'(nn); r++) begin
                seg = use_fixed ? fixed_seg : {$urandom, $urandom, $urandom, $urandom};
                c = (int'(mm) - 16 * t >= 16) ? 16 : int'(mm) - 16 * t;
                model_seg(longint'(b) + longint'(r) * longint'(s) + 16 * t, c, seg);
                send_seg(seg);
                idx++;
                wait_done(d0 + idx);
                check("over_cnt_seg", over_cnt - o0, (idx == tt * int'(nn)) ? 1 : 0);
            end
        end
        repeat (2) @(negedge clk);
        check("n_words", got_addr.size(), exp_addr.size());
        nw = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < nw; i++) begin
            check("addr", got_addr[i], exp_addr[i]);
            check("mask", got_mask[i], exp_mask[i]);
            check("wdata", got_data[i] & mask_bits(exp_mask[i]), exp_data[i]);
        end
        check("done_cnt", done_cnt - d0, tt * int'(nn));
        $display("matrix base=0x%0h stride=%0d n=%0d m=%0d: %0d words, %0d done", b, s, nn, mm,
                 got_addr.size(), done_cnt - d0);
    endtask

    initial begin
        int k, d_before;
        init_cfg_oa = 1'b0;
        dst_base = '0; dst_row_stride_b = '0; n = '0; m = '0;
        in_valid = 1'b0;
        in_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_req", write_oa_req, 0);
        check("rst_done", write_done, 0);
        check("rst_over", oa_calc_over, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_cmd_valid", icb_cmd_valid, 0);
        check("rst_cmd_addr", icb_cmd_addr, 0);
        check("rst_wdata", icb_cmd_wdata, 0);
        check("rst_wmask", icb_cmd_wmask, 0);
        check("rst_rsp_ready", icb_rsp_ready, 1);
        check("cmd_read", icb_cmd_read, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Aligned full tile
        run_matrix(32'h1000, 16, 2, 16, 1);
        check("t1_words", got_addr.size(), 8);
        if (got_addr.size() == 8) begin
            check("t1_first", got_addr[0], 32'h1000);
            check("t1_last", got_addr[7], 32'h101C);
        end

        // Partial last tile
        run_matrix(32'h2000, 16, 1, 20, 1);
        check("t2_words", got_addr.size(), 5);
        if (got_addr.size() == 5) begin
            check("t2_tail_addr", got_addr[4], 32'h2010);
            check("t2_tail_mask", got_mask[4], 4'hF);
        end

        // Unaligned base
        use_fixed = 1;
        fixed_seg = 128'h44332211;
        run_matrix(32'h3002, 16, 1, 4, 1);
        use_fixed = 0;
        check("t3_words", got_addr.size(), 2);
        if (got_addr.size() == 2) begin
            check("t3_addr0", got_addr[0], 32'h3000);
            check("t3_data0", got_data[0][31:16], 16'h2211);
            check("t3_mask0", got_mask[0], 4'hC);
            check("t3_addr1", got_addr[1], 32'h3004);
            check("t3_data1", got_data[1][15:0], 16'h4433);
            check("t3_mask1", got_mask[1], 4'h3);
        end

        // Backpressure and grant delay
        ready_mode = 1; grant_delay = 5; rsp_delay = 3;
        run_matrix(32'h1100, 16, 1, 16, 1);
        check("bp_stall_stable", stall_err, 0);
        check("bp_req_continuous", drop_err, 0);
        ready_mode = 0; grant_delay = 0; rsp_delay = 0;

        // Error response on word 2 of segment 0
        err_idx = cmd_num + 2;
        run_matrix(32'h6000, 16, 2, 16, 1);
        err_idx = -1;
        check("err_set", wr_err, 1);
        pulse_init(32'h6000, 16, 2, 16);
        @(negedge clk);
        check("err_cleared", wr_err, 0);

        // Abort during CMD of segment 1
        allow_drop = 1;
        pulse_init(32'h4000, 32, 2, 16);
        send_seg({$urandom, $urandom, $urandom, $urandom});
        wait_done(done_cnt + 1);
        d_before = done_cnt;
        send_seg({$urandom, $urandom, $urandom, $urandom});
        k = 0;
        while (!icb_cmd_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("abort_in_cmd", icb_cmd_valid, 1);
        @(posedge clk); #1;
        dst_base = 32'h5008; dst_row_stride_b = 16; n = 1; m = 8;
        init_cfg_oa = 1'b1;
        @(posedge clk); #1;
        init_cfg_oa = 1'b0;
        @(negedge clk);
        check("abort_req_low", write_oa_req, 0);
        check("abort_valid_low", icb_cmd_valid, 0);
        check("abort_in_ready", in_ready, 1);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt, d_before);
        allow_drop = 0;
        run_matrix(32'h5008, 16, 1, 8, 0);

        // Asynchronous reset while waiting for responses
        allow_drop = 1;
        rsp_delay = 8;
        got_addr.delete(); got_data.delete(); got_mask.delete();
        pulse_init(32'h7000, 16, 1, 16);
        send_seg({$urandom, $urandom, $urandom, $urandom});
        k = 0;
        while (!(got_addr.size() == 4 && !icb_cmd_valid && write_oa_req) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rsp_wait_reached", write_oa_req, 1);
        rst_n = 1'b0;
        #1;
        check("arst_req", write_oa_req, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_done", write_done, 0);
        check("arst_over", oa_calc_over, 0);
        check("arst_cmd_valid", icb_cmd_valid, 0);
        check("arst_cmd_addr", icb_cmd_addr, 0);
        check("arst_wdata", icb_cmd_wdata, 0);
        check("arst_wmask", icb_cmd_wmask, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", in_ready, 0);
        check("post_rst_req", write_oa_req, 0);
        repeat (15) @(negedge clk);
        rsp_delay = 0;
        allow_drop = 0;

        // Randomized matrices and bus behaviour
        for (int it = 0; it < 8; it++) begin
            logic [31:0] rb, rn, rm, rs;
            rb = 32'h8000 + $urandom_range(0, 63);
            rn = $urandom_range(1, 3);
            rm = $urandom_range(1, 40);
            rs = rm + $urandom_range(0, 7);
            ready_mode = $urandom_range(0, 1);
            grant_delay = $urandom_range(0, 3);
            rsp_delay = $urandom_range(0, 3);
            run_matrix(rb, rs, rn, rm, 1);
        end

        check("stall_stable", stall_err, 0);
        check("req_continuous", drop_err, 0);
        check("over_with_done", over_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
